// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpu_pkg
// Brief    : Shared FPU types, flag indices and format helper functions.
// Revision : 1.0
// ============================================================================
package fpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_UNPACK = 3'd1,
        ST_DIV    = 3'd2,
        ST_NORM   = 3'd3,
        ST_ROUND  = 3'd4,
        ST_DONE   = 3'd5
    } state_e;

    typedef enum logic [2:0] {
        CLS_ZERO = 3'd0,
        CLS_NORM = 3'd1,
        CLS_INF  = 3'd2,
        CLS_QNAN = 3'd3,
        CLS_SNAN = 3'd4
    } cls_e;

    // Bit positions within the 5-bit flags word {NV, DZ, OF, UF, NX}
    localparam int FLG_NX = 0;
    localparam int FLG_UF = 1;
    localparam int FLG_OF = 2;
    localparam int FLG_DZ = 3;
    localparam int FLG_NV = 4;

    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    function automatic int exp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_fdiv_ieee_if.sv
`default_nettype none
// ============================================================================
// Module   : fpu_fdiv_ieee_if
// Brief    : Operand/result valid-ready bundle for the FPU divider.
// Revision : 1.0
// ============================================================================
interface fpu_fdiv_ieee_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] q;
    logic [4:0]   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, flags
    );
endinterface
`default_nettype wire

// File: rtl/fpu_classify.sv
`default_nettype none
// ============================================================================
// Module   : fpu_classify
// Brief    : Combinational IEEE-754 operand classifier; subnormals read as zero.
// Revision : 1.0
// ============================================================================
module fpu_classify
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic [EXP_W-1:0] exp_i,
    input  logic [MAN_W-1:0] man_i,
    output cls_e             cls_o
);
    always_comb begin
        cls_o = CLS_NORM;
        if (exp_i == '0) begin
            cls_o = CLS_ZERO;
        end else if (&exp_i) begin
            if (man_i == '0)             cls_o = CLS_INF;
            else if (man_i[MAN_W-1])     cls_o = CLS_QNAN;
            else                         cls_o = CLS_SNAN;
        end
    end
endmodule
`default_nettype wire

// File: rtl/fpu_fdiv_ieee.sv
`default_nettype none
// ============================================================================
// Module   : fpu_fdiv_ieee
// Brief    : Iterative radix-2 IEEE-754 divider, RNE rounding, DAZ/FTZ, flags.
// Revision : 1.0
// ============================================================================
module fpu_fdiv_ieee
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    fpu_fdiv_ieee_if.slave bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int N  = MAN_W + 3;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(N + 1);

    localparam logic [W-1:0]         C_QNAN = W'(canon_nan(EXP_W, MAN_W));
    localparam logic signed [EW-1:0] C_BIAS = EW'(exp_bias(EXP_W));
    localparam logic signed [EW-1:0] C_EMAX = EW'((1 << EXP_W) - 1);
    localparam logic [CW-1:0]        C_LAST = CW'(N - 1);

    state_e                 state_q;
    logic                   in_ready_q, out_valid_q, sign_q, grd_q, stk_q;
    logic [W-2:0]           a_q, b_q;
    logic [W-1:0]           q_q;
    logic [4:0]             flags_q;
    logic [MAN_W+1:0]       rem_q;
    logic [MAN_W:0]         div_q, sig_q;
    logic [MAN_W+2:0]       quo_q;
    logic [CW-1:0]          cnt_q;
    logic signed [EW-1:0]   exp_q;

    cls_e w_ca, w_cb;

    fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_a (
        .exp_i (a_q[W-2 -: EXP_W]),
        .man_i (a_q[MAN_W-1:0]),
        .cls_o (w_ca)
    );

    fpu_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_cls_b (
        .exp_i (b_q[W-2 -: EXP_W]),
        .man_i (b_q[MAN_W-1:0]),
        .cls_o (w_cb)
    );

    logic         w_spec;
    logic [W-1:0] w_spec_q, w_inf, w_zero;
    logic [4:0]   w_spec_f;

    always_comb begin
        w_inf    = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_zero   = {sign_q, {(W-1){1'b0}}};
        w_spec   = 1'b1;
        w_spec_q = '0;
        w_spec_f = '0;
        if (w_ca == CLS_QNAN || w_ca == CLS_SNAN || w_cb == CLS_QNAN || w_cb == CLS_SNAN) begin
            w_spec_q         = C_QNAN;
            w_spec_f[FLG_NV] = (w_ca == CLS_SNAN) || (w_cb == CLS_SNAN);
        end else if ((w_ca == CLS_ZERO && w_cb == CLS_ZERO) || (w_ca == CLS_INF && w_cb == CLS_INF)) begin
            w_spec_q         = C_QNAN;
            w_spec_f[FLG_NV] = 1'b1;
        end else if (w_ca == CLS_INF) begin
            w_spec_q = w_inf;
        end else if (w_cb == CLS_ZERO) begin
            w_spec_q         = w_inf;
            w_spec_f[FLG_DZ] = 1'b1;
        end else if (w_ca == CLS_ZERO || w_cb == CLS_INF) begin
            w_spec_q = w_zero;
        end else begin
            w_spec = 1'b0;
        end
    end

    // Restoring step: rem < 2*div always holds, so the difference fits MAN_W+1 bits
    logic                   w_ge;
    logic [MAN_W:0]         w_sub;
    logic [MAN_W+1:0]       w_rem_nx;

    always_comb begin
        w_ge     = rem_q >= {1'b0, div_q};
        w_sub    = rem_q[MAN_W:0] - div_q;
        w_rem_nx = w_ge ? {w_sub, 1'b0} : {rem_q[MAN_W:0], 1'b0};
    end

    logic                   w_inc;
    logic [MAN_W+1:0]       w_sum;
    logic [MAN_W-1:0]       w_frac;
    logic signed [EW-1:0]   w_exp_r;
    logic [W-1:0]           w_rnd_q;
    logic [4:0]             w_rnd_f;

    always_comb begin
        w_inc   = grd_q & (stk_q | sig_q[0]);
        w_sum   = {1'b0, sig_q} + {{(MAN_W+1){1'b0}}, w_inc};
        w_frac  = w_sum[MAN_W+1] ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
        w_exp_r = exp_q + {{(EW-1){1'b0}}, w_sum[MAN_W+1]};
        w_rnd_q = {sign_q, w_exp_r[EXP_W-1:0], w_frac};
        w_rnd_f = '0;
        w_rnd_f[FLG_NX] = grd_q | stk_q;
        if (w_exp_r >= C_EMAX) begin
            w_rnd_q         = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_rnd_f[FLG_OF] = 1'b1;
            w_rnd_f[FLG_NX] = 1'b1;
        end else if (w_exp_r[EW-1] || w_exp_r == '0) begin
            w_rnd_q         = {sign_q, {(W-1){1'b0}}};
            w_rnd_f[FLG_UF] = 1'b1;
            w_rnd_f[FLG_NX] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_q         <= '0;
            flags_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            rem_q       <= '0;
            div_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            exp_q       <= '0;
            sig_q       <= '0;
            grd_q       <= 1'b0;
            stk_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.in_valid) begin
                    a_q        <= bus.a[W-2:0];
                    b_q        <= bus.b[W-2:0];
                    sign_q     <= bus.a[W-1] ^ bus.b[W-1];
                    in_ready_q <= 1'b0;
                    state_q    <= ST_UNPACK;
                end
                ST_UNPACK: if (w_spec) begin
                    q_q     <= w_spec_q;
                    flags_q <= w_spec_f;
                    state_q <= ST_DONE;
                end else begin
                    rem_q   <= {2'b01, a_q[MAN_W-1:0]};
                    div_q   <= {1'b1, b_q[MAN_W-1:0]};
                    exp_q   <= $signed({2'b00, a_q[W-2 -: EXP_W]}) - $signed({2'b00, b_q[W-2 -: EXP_W]}) + C_BIAS;
                    quo_q   <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_DIV;
                end
                ST_DIV: begin
                    rem_q <= w_rem_nx;
                    quo_q <= {quo_q[MAN_W+1:0], w_ge};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == C_LAST) state_q <= ST_NORM;
                end
                ST_NORM: begin
                    if (quo_q[MAN_W+2]) begin
                        sig_q <= quo_q[MAN_W+2:2];
                        grd_q <= quo_q[1];
                        stk_q <= quo_q[0] | (|rem_q);
                    end else begin
                        sig_q <= quo_q[MAN_W+1:1];
                        grd_q <= quo_q[0];
                        stk_q <= |rem_q;
                        exp_q <= exp_q - EW'(1);
                    end
                    state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    q_q         <= w_rnd_q;
                    flags_q     <= w_rnd_f;
                    out_valid_q <= 1'b1;
                    state_q     <= ST_DONE;
                end
                ST_DONE: begin
                    // Special results arrive without out_valid and publish on the next cycle
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.q         = q_q;
    assign bus.flags     = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu_fdiv_ieee.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_fdiv_ieee
// Brief    : Scoreboard bench for single- and half-precision divider instances.
// Revision : 1.0
// ============================================================================
module tb_fpu_fdiv_ieee;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fpu_fdiv_ieee_if #(.EXP_W(8), .MAN_W(23)) bs ();
    fpu_fdiv_ieee_if #(.EXP_W(5), .MAN_W(10)) bh ();

    fpu_fdiv_ieee #(.EXP_W(8), .MAN_W(23)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bs.slave));
    fpu_fdiv_ieee #(.EXP_W(5), .MAN_W(10)) dut_h (.clk(clk), .rst_n(rst_n), .bus(bh.slave));

    typedef struct {
        logic [31:0] q;
        logic [4:0]  f;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic send_s(input logic [31:0] a, input logic [31:0] b);
        bs.a = a; bs.b = b; bs.in_valid = 1'b1;
        @(posedge clk); #1 bs.in_valid = 1'b0;
    endtask

    task automatic send_h(input logic [15:0] a, input logic [15:0] b);
        bh.a = a; bh.b = b; bh.in_valid = 1'b1;
        @(posedge clk); #1 bh.in_valid = 1'b0;
    endtask

    // Edge count starts at the accept edge (edge 0)
    task automatic wait_s(output int lat, output bit tmo);
        lat = 0; tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); lat++; #1;
            if (bs.out_valid === 1'b1) begin tmo = 1'b0; break; end
        end
    endtask

    task automatic wait_h(output int lat, output bit tmo);
        lat = 0; tmo = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); lat++; #1;
            if (bh.out_valid === 1'b1) begin tmo = 1'b0; break; end
        end
    endtask

    task automatic take_s();
        bs.out_ready = 1'b1; @(posedge clk); #1 bs.out_ready = 1'b0;
    endtask

    task automatic take_h();
        bh.out_ready = 1'b1; @(posedge clk); #1 bh.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bs.in_ready !== 1'b1 || bs.out_valid !== 1'b0 || bs.q !== 32'h0 || bs.flags !== 5'h0) begin
            errors++;
            $display("FAIL reset_single: in_ready=%b out_valid=%b q=%h flags=%b, expected 1 0 00000000 00000",
                     bs.in_ready, bs.out_valid, bs.q, bs.flags);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bh.in_ready !== 1'b1 || bh.out_valid !== 1'b0 || bh.q !== 16'h0) begin
            errors++;
            $display("FAIL reset_half: in_ready=%b out_valid=%b q=%h, expected 1 0 0000",
                     bh.in_ready, bh.out_valid, bh.q);
        end
    endtask

    task automatic test_normal();
        logic [31:0] ta [2] = '{32'h40C00000, 32'h3F800000};
        logic [31:0] tb [2] = '{32'h40000000, 32'h40400000};
        logic [31:0] tq [2] = '{32'h40400000, 32'h3EAAAAAB};
        logic [4:0]  tf [2] = '{5'b00000,     5'b00001};
        for (int i = 0; i < 2; i++) begin
            int lat; bit tmo; exp_t e;
            sb.push_back('{tq[i], tf[i], 29});
            send_s(ta[i], tb[i]);
            wait_s(lat, tmo);
            e = sb.pop_front();
            checks++;
            if (tmo || bs.q !== e.q || bs.flags !== e.f || lat != e.lat) begin
                errors++;
                $display("FAIL normal[%0d]: q=%h flags=%b lat=%0d timeout=%b, expected q=%h flags=%b lat=%0d",
                         i, bs.q, bs.flags, lat, tmo, e.q, e.f, e.lat);
            end
            take_s();
        end
    endtask

    task automatic test_specials();
        logic [31:0] ta [4] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800001};
        logic [31:0] tb [4] = '{32'h00000000, 32'h00000000, 32'h7F800000, 32'h3F800000};
        logic [31:0] tq [4] = '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000};
        logic [4:0]  tf [4] = '{5'b01000,     5'b10000,     5'b10000,     5'b10000};
        for (int i = 0; i < 4; i++) begin
            int lat; bit tmo; exp_t e;
            sb.push_back('{tq[i], tf[i], 2});
            send_s(ta[i], tb[i]);
            wait_s(lat, tmo);
            e = sb.pop_front();
            checks++;
            if (tmo || bs.q !== e.q || bs.flags !== e.f || lat != e.lat) begin
                errors++;
                $display("FAIL special[%0d]: q=%h flags=%b lat=%0d timeout=%b, expected q=%h flags=%b lat=%0d",
                         i, bs.q, bs.flags, lat, tmo, e.q, e.f, e.lat);
            end
            take_s();
        end
    endtask

    task automatic test_range();
        logic [31:0] ta [3] = '{32'h7F7FFFFF, 32'h00800000, 32'h80000001};
        logic [31:0] tb [3] = '{32'h3F000000, 32'h40000000, 32'h3F800000};
        logic [31:0] tq [3] = '{32'h7F800000, 32'h00000000, 32'h80000000};
        logic [4:0]  tf [3] = '{5'b00101,     5'b00011,     5'b00000};
        int          tl [3] = '{29, 29, 2};
        for (int i = 0; i < 3; i++) begin
            int lat; bit tmo; exp_t e;
            sb.push_back('{tq[i], tf[i], tl[i]});
            send_s(ta[i], tb[i]);
            wait_s(lat, tmo);
            e = sb.pop_front();
            checks++;
            if (tmo || bs.q !== e.q || bs.flags !== e.f || lat != e.lat) begin
                errors++;
                $display("FAIL range[%0d]: q=%h flags=%b lat=%0d timeout=%b, expected q=%h flags=%b lat=%0d",
                         i, bs.q, bs.flags, lat, tmo, e.q, e.f, e.lat);
            end
            take_s();
        end
    endtask

    task automatic test_back_pressure();
        int lat; bit tmo; exp_t e;
        sb.push_back('{32'h40400000, 5'b00000, 29});
        send_s(32'h40C00000, 32'h40000000);
        wait_s(lat, tmo);
        e = sb.pop_front();
        checks++;
        if (tmo || bs.q !== e.q || bs.flags !== e.f) begin
            errors++;
            $display("FAIL bp_result: q=%h flags=%b timeout=%b, expected q=%h flags=%b",
                     bs.q, bs.flags, tmo, e.q, e.f);
        end
        bs.a = 32'h3F800000; bs.b = 32'h40400000; bs.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (bs.out_valid !== 1'b1 || bs.q !== e.q || bs.flags !== e.f || bs.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b q=%h flags=%b in_ready=%b, expected 1 %h %b 0",
                         i, bs.out_valid, bs.q, bs.flags, bs.in_ready, e.q, e.f);
            end
        end
        bs.in_valid  = 1'b0;
        take_s();
        checks++;
        if (bs.out_valid !== 1'b0 || bs.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: out_valid=%b in_ready=%b, expected 0 1", bs.out_valid, bs.in_ready);
        end
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (bs.out_valid !== 1'b0 || bs.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_no_accept: out_valid=%b in_ready=%b, expected 0 1", bs.out_valid, bs.in_ready);
        end
    endtask

    task automatic test_reset_mid_div();
        int lat; bit tmo; exp_t e; bit seen;
        sb.push_back('{32'h40400000, 5'b00000, 29});
        send_s(32'h40C00000, 32'h40000000);
        repeat (9) @(posedge clk);
        @(posedge clk);
        rst_n = 1'b0;
        sb.delete();
        #1;
        checks++;
        if (bs.out_valid !== 1'b0 || bs.in_ready !== 1'b1 || bs.q !== 32'h0 || bs.flags !== 5'h0) begin
            errors++;
            $display("FAIL rst_mid_div: out_valid=%b in_ready=%b q=%h flags=%b, expected 0 1 00000000 00000",
                     bs.out_valid, bs.in_ready, bs.q, bs.flags);
        end
        @(negedge clk); @(negedge clk) rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bs.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL rst_partial: out_valid=1 after abort, expected 0");
        end
        sb.push_back('{32'h40400000, 5'b00000, 29});
        send_s(32'h40C00000, 32'h40000000);
        wait_s(lat, tmo);
        e = sb.pop_front();
        checks++;
        if (tmo || bs.q !== e.q || bs.flags !== e.f || lat != e.lat) begin
            errors++;
            $display("FAIL rst_recover: q=%h flags=%b lat=%0d timeout=%b, expected q=%h flags=%b lat=%0d",
                     bs.q, bs.flags, lat, tmo, e.q, e.f, e.lat);
        end
        take_s();
    endtask

    task automatic test_half();
        logic [15:0] ta [2] = '{16'h3C00, 16'h3C00};
        logic [15:0] tb [2] = '{16'h4000, 16'h4200};
        logic [15:0] tq [2] = '{16'h3800, 16'h3555};
        logic [4:0]  tf [2] = '{5'b00000, 5'b00001};
        for (int i = 0; i < 2; i++) begin
            int lat; bit tmo; exp_t e;
            sb.push_back('{{16'h0, tq[i]}, tf[i], 16});
            send_h(ta[i], tb[i]);
            wait_h(lat, tmo);
            e = sb.pop_front();
            checks++;
            if (tmo || bh.q !== e.q[15:0] || bh.flags !== e.f || lat != e.lat) begin
                errors++;
                $display("FAIL half[%0d]: q=%h flags=%b lat=%0d timeout=%b, expected q=%h flags=%b lat=%0d",
                         i, bh.q, bh.flags, lat, tmo, e.q[15:0], e.f, e.lat);
            end
            take_h();
        end
    endtask

    initial begin
        bs.in_valid = 1'b0; bs.out_ready = 1'b0; bs.a = '0; bs.b = '0;
        bh.in_valid = 1'b0; bh.out_ready = 1'b0; bh.a = '0; bh.b = '0;
        test_reset();
        test_normal();
        test_specials();
        test_range();
        test_back_pressure();
        test_reset_mid_div();
        test_half();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
